// File: rtl/uart_vga_loader.sv
// 8N1 UART receiver that streams bytes into a display RAM write port.
// Wraps the address at the end of a frame and rewinds it after a long idle line.
module uart_vga_loader #(
   parameter int CLKS_PER_BIT    = 742,
   parameter int BYTES_PER_FRAME = 920,
   parameter int IDLE_BITS       = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [31:0] write_address,
   output logic [7:0]  ram_in,
   output logic        we,
   output logic        frame_done,
   output logic        rx_error
);

   localparam int CNT_W      = $clog2(CLKS_PER_BIT);
   localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
   localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
   localparam int ADDR_W     = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;

   localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_LIMIT);
   localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic               r_rxMeta;
   logic               r_rxSync;
   logic               w_rxS;
   logic [CNT_W-1:0]   r_bitCnt;
   logic [CNT_W-1:0]   w_bitCntNext;
   logic [2:0]         r_bitIdx;
   logic [2:0]         w_bitIdxNext;
   logic [7:0]         r_shift;
   logic [7:0]         w_shiftNext;
   logic               w_accept;
   logic               w_frameErr;
   logic [IDLE_W-1:0]  r_idleCnt;
   logic               w_idleRun;
   logic               w_timeout;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W-1:0]  r_writeAddr;
   logic [7:0]         r_ramIn;
   logic               r_we;
   logic               r_frameDone;
   logic               r_rxError;

   assign w_rxS = r_rxSync;

   // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
      end else begin
         r_rxMeta <= uart_rx;
         r_rxSync <= r_rxMeta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_bitCnt <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_bitCnt <= w_bitCntNext;
         r_bitIdx <= w_bitIdxNext;
         r_shift  <= w_shiftNext;
      end
   end

   // Start bit is checked at mid-bit, then every later sample lands one full bit further on.
   always_comb begin
      w_stateNext  = r_state;
      w_bitCntNext = r_bitCnt;
      w_bitIdxNext = r_bitIdx;
      w_shiftNext  = r_shift;
      w_accept     = 1'b0;
      w_frameErr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rxS) begin
               w_stateNext  = START;
               w_bitCntNext = '0;
            end
         end
         START: begin
            if (r_bitCnt == HALF_BIT) begin
               w_bitCntNext = '0;
               if (!w_rxS) begin
                  w_stateNext  = DATA;
                  w_bitIdxNext = '0;
               end else begin
                  w_stateNext = IDLE;
               end
            end else begin
               w_bitCntNext = r_bitCnt + CNT_ONE;
            end
         end
         DATA: begin
            if (r_bitCnt == FULL_BIT) begin
               w_bitCntNext = '0;
               w_shiftNext  = {w_rxS, r_shift[7:1]};
               if (r_bitIdx == 3'd7) begin
                  w_stateNext = STOP;
               end else begin
                  w_bitIdxNext = r_bitIdx + 3'd1;
               end
            end else begin
               w_bitCntNext = r_bitCnt + CNT_ONE;
            end
         end
         STOP: begin
            if (r_bitCnt == FULL_BIT) begin
               w_bitCntNext = '0;
               w_stateNext  = IDLE;
               w_accept     = w_rxS;
               w_frameErr   = !w_rxS;
            end else begin
               w_bitCntNext = r_bitCnt + CNT_ONE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   assign w_idleRun = (r_state == IDLE) && w_rxS;
   assign w_timeout = (r_idleCnt == IDLE_MAX);

   // Idle counter saturates at the limit so the rewind stays armed until the next start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idleCnt <= '0;
      end else if (w_idleRun) begin
         if (r_idleCnt != IDLE_MAX) begin
            r_idleCnt <= r_idleCnt + IDLE_ONE;
         end
      end else begin
         r_idleCnt <= '0;
      end
   end

   // Accept and timeout are mutually exclusive: timeout needs a long IDLE run, accept happens in STOP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr      <= '0;
         r_writeAddr <= '0;
         r_ramIn     <= '0;
         r_we        <= 1'b0;
         r_frameDone <= 1'b0;
         r_rxError   <= 1'b0;
      end else begin
         r_we        <= 1'b0;
         r_frameDone <= 1'b0;
         r_rxError   <= w_frameErr;
         if (w_accept) begin
            r_writeAddr <= r_addr;
            r_ramIn     <= r_shift;
            r_we        <= 1'b1;
            if (r_addr == LAST_ADDR) begin
               r_addr      <= '0;
               r_frameDone <= 1'b1;
            end else begin
               r_addr <= r_addr + ADDR_ONE;
            end
         end else if (w_timeout) begin
            r_addr <= '0;
         end
      end
   end

   assign write_address = {{(32 - ADDR_W){1'b0}}, r_writeAddr};
   assign ram_in        = r_ramIn;
   assign we            = r_we;
   assign frame_done    = r_frameDone;
   assign rx_error      = r_rxError;

endmodule

// File: tb/tb_uart_vga_loader.sv
// Directed bench for uart_vga_loader: a byte-level model predicts every RAM write and error pulse,
// and a per-cycle compare process checks the DUT against it.
module tb_uart_vga_loader;

   localparam int CPB   = 4;
   localparam int BPF   = 4;
   localparam int IBITS = 3;
   localparam int LIMIT = IBITS * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_rx;
   logic [31:0] write_address;
   logic [7:0]  ram_in;
   logic        we;
   logic        frame_done;
   logic        rx_error;

   typedef struct {
      int addr;
      int data;
      int last;
   } wr_t;

   int  checks = 0;
   int  errors = 0;
   int  cycleNo = 0;
   int  startCycle = 0;
   int  lastWeCycle = 0;
   int  modelAddr = 0;
   int  idleRun = 0;
   int  expErrs = 0;
   int  lastAddr = 0;
   int  lastData = 0;
   bit  checking = 1'b0;
   wr_t expQ[$];
   wr_t seen[$];

   uart_vga_loader #(
      .CLKS_PER_BIT(CPB),
      .BYTES_PER_FRAME(BPF),
      .IDLE_BITS(IBITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .uart_rx(uart_rx),
      .write_address(write_address),
      .ram_in(ram_in),
      .we(we),
      .frame_done(frame_done),
      .rx_error(rx_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleNo <= cycleNo + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Byte-level model: each good byte lands at the pointer, which wraps per frame and rewinds after a long idle line.
   task automatic modelByte(input logic [7:0] data, input bit stopOk);
      wr_t e;
      if (stopOk) begin
         e.addr = modelAddr;
         e.data = int'(data);
         e.last = (modelAddr == BPF - 1) ? 1 : 0;
         expQ.push_back(e);
         modelAddr = (modelAddr + 1) % BPF;
      end else begin
         expErrs++;
      end
   endtask

   task automatic idleLine(input int n);
      repeat (n) @(negedge clk);
      idleRun += n;
      if (idleRun >= LIMIT) modelAddr = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] data, input bit stopOk);
      modelByte(data, stopOk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = data[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stopOk;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      idleRun = 0;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_addr", write_address, 32'h0);
      checkOutput("rst_data", 32'(ram_in), 32'h0);
      checkOutput("rst_we", 32'(we), 32'h0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
      checkOutput("rst_rx_error", 32'(rx_error), 32'h0);
      expQ.delete();
      seen.delete();
      expErrs = 0;
      modelAddr = 0;
      idleRun = 0;
      lastAddr = 0;
      lastData = 0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain();
      idleLine(2 * CPB);
      checkOutput("drain_writes", 32'(expQ.size()), 32'h0);
      checkOutput("drain_errors", 32'(expErrs), 32'h0);
   endtask

   // Every cycle: writes must match the model in order, and outputs must hold between writes.
   always @(negedge clk) begin
      wr_t e;
      wr_t s;
      if (checking && !rst) begin
         if (we === 1'b1) begin
            lastWeCycle = cycleNo;
            s.addr = int'(write_address);
            s.data = int'(ram_in);
            s.last = int'(frame_done);
            seen.push_back(s);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_we: got addr %0h data %0h, expected no write", write_address, ram_in);
            end else begin
               e = expQ.pop_front();
               checkOutput("wr_addr", write_address, 32'(e.addr));
               checkOutput("wr_data", 32'(ram_in), 32'(e.data));
               checkOutput("wr_frame_done", 32'(frame_done), 32'(e.last));
               lastAddr = e.addr;
               lastData = e.data;
            end
         end else begin
            checkOutput("idle_frame_done", 32'(frame_done), 32'h0);
            checkOutput("hold_addr", write_address, 32'(lastAddr));
            checkOutput("hold_data", 32'(ram_in), 32'(lastData));
         end
         if (rx_error === 1'b1) begin
            checks++;
            if (expErrs == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_rx_error: got 1, expected 0");
            end else begin
               expErrs--;
            end
         end
      end
   end

   initial begin
      int expA[5];
      int expF[5];
      expA = '{0, 1, 2, 3, 0};
      expF = '{0, 0, 0, 1, 0};
      rst = 1'b1;
      uart_rx = 1'b1;
      pulseReset();
      checking = 1'b1;

      $display("[TB] single byte after reset");
      idleLine(2);
      startCycle = cycleNo;
      applyStimulus(8'hA5, 1'b1);
      drain();
      checkOutput("s1_count", 32'(seen.size()), 32'd1);
      if (seen.size() == 1) begin
         checkOutput("s1_addr", 32'(seen[0].addr), 32'h0);
         checkOutput("s1_data", 32'(seen[0].data), 32'hA5);
         checkOutput("s1_latency", 32'(lastWeCycle - startCycle), 32'd41);
      end

      $display("[TB] back-to-back bytes across a frame wrap");
      pulseReset();
      for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
      drain();
      checkOutput("s2_count", 32'(seen.size()), 32'd5);
      if (seen.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput("s2_addr", 32'(seen[i].addr), 32'(expA[i]));
            checkOutput("s2_frame_done", 32'(seen[i].last), 32'(expF[i]));
         end
      end

      $display("[TB] framing error then recovery");
      seen.delete();
      applyStimulus(8'h3C, 1'b0);
      idleLine(CPB);
      applyStimulus(8'h11, 1'b1);
      drain();
      checkOutput("s3_count", 32'(seen.size()), 32'd1);
      if (seen.size() == 1) begin
         checkOutput("s3_addr", 32'(seen[0].addr), 32'h1);
         checkOutput("s3_data", 32'(seen[0].data), 32'h11);
      end

      $display("[TB] one-cycle glitch in idle");
      seen.delete();
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      idleRun = 0;
      idleLine(8);
      checkOutput("s4_no_write", 32'(seen.size()), 32'd0);
      applyStimulus(8'h22, 1'b1);
      drain();
      checkOutput("s4_count", 32'(seen.size()), 32'd1);
      if (seen.size() == 1) checkOutput("s4_addr", 32'(seen[0].addr), 32'h2);

      $display("[TB] idle timeout rewinds the pointer");
      pulseReset();
      applyStimulus(8'h10, 1'b1);
      applyStimulus(8'h20, 1'b1);
      idleLine(LIMIT);
      applyStimulus(8'h77, 1'b1);
      idleLine(5);
      applyStimulus(8'h78, 1'b1);
      drain();
      checkOutput("s5_count", 32'(seen.size()), 32'd4);
      if (seen.size() == 4) begin
         checkOutput("s5_timeout_addr", 32'(seen[2].addr), 32'h0);
         checkOutput("s5_timeout_data", 32'(seen[2].data), 32'h77);
         checkOutput("s5_short_idle_addr", 32'(seen[3].addr), 32'h1);
      end

      $display("[TB] reset in the middle of a byte");
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = i[0];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (2) @(negedge clk);
      pulseReset();
      applyStimulus(8'h5A, 1'b1);
      drain();
      checkOutput("s6_count", 32'(seen.size()), 32'd1);
      if (seen.size() == 1) begin
         checkOutput("s6_addr", 32'(seen[0].addr), 32'h0);
         checkOutput("s6_data", 32'(seen[0].data), 32'h5A);
      end

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
